rx_substate_evaluator: RTL and testbench
========================================

Name: rx_substate_evaluator

Overview:
- Parametrised successor to the master RX LTSSM evaluator.
- Accepts a substate request from the main LTSSM and arms the per-lane ordered-set checkers.
- Runs its own millisecond timer and judges per-lane match counts against a per-substate requirement.
- Returns one finish pulse with exit substate, exit reason and a per-lane pass map. Adds lane masking, mid-operation abort and configurable timer resolution.

Parameters:
- MAXLANES, 16, number of lanes evaluated (1..32).
- CNTW, 5, width of each per-lane match count.
- TICKS_PER_MS, 1000, clk cycles per millisecond.
- TMR_W, 32, timer counter width; must hold 48*TICKS_PER_MS.
- DEVICETYPE, 0, 0 = downstream port, 1 = upstream port.
- GEN1_PIPEWIDTH..GEN5_PIPEWIDTH, 8, PIPE symbol width per generation.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- substate  in  5  requested LTSSM substate (encoding 0..20: detectQuiet=0 … recoverywait=20).
- substateValid  in  1  request strobe; sampled each cycle.
- laneMask  in  MAXLANES  lanes participating.
- laneCount  in  MAXLANES*CNTW  per-lane consecutive ordered-set match counts; lane i = bits [i*CNTW +: CNTW].
- rxElectricalIdle  in  1  receiver electrical idle.
- gen  in  3  current generation 1..5.
- trainToGen  in  3  target generation.
- rcvrCfgToIdle  in  1  forces exit to recoveryIdle on match.
- eqRedo  in  1  phase1 redo request.
- finish  out  1  single-cycle completion pulse.
- exitTo  out  5  next substate.
- exitReason  out  2  00 match, 01 timeout-advance, 10 timeout-fail, 11 aborted.
- lanesPassed  out  MAXLANES  lanes that met the requirement, valid with finish.
- resetOsCheckers  out  MAXLANES  active-high checker enable per lane.
- busy  out  1  high in ARM/COUNT.

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, lastSub = 5'h1F.
- States:
  - IDLE -> ARM when substateValid and substate != lastSub. Latch lastSub and the requirement: reqCnt, tms.
  - ARM (1 cycle): resetOsCheckers = 0 to clear the checkers; timer loads tms*TICKS_PER_MS.
  - ARM -> COUNT: resetOsCheckers = laneMask; timer decrements each cycle; timeout when timer == 0.
  - COUNT -> DONE on match, timeout, or abort.
  - DONE (1 cycle): finish = 1; resetOsCheckers = 0; -> IDLE.
- Requirement table (reqCnt, tms):
  - detectQuiet, detectActive: 0, 0.
  - pollingActive, configurationComplete: 8, 24.
  - configurationLinkWidthStart/Accept, configurationLanenumAccept, phase0..3: 2, 24. Exception: phase1 with DEVICETYPE=0 uses 0, 24.
  - configurationLanenumWait: 2, 2.
  - pollingConfiguration, recoveryRcvrLock, recoveryRcvrCfg: 8, 48.
  - configurationIdle, recoveryIdle: 64/GENn_PIPEWIDTH for the current gen, 2.
  - recoverySpeed, recoverySpeedeieos, and L0 when DEVICETYPE=1: 1, 48.
  - Any other substate: request ignored; stays IDLE.
- Match: laneMask != 0 and every masked lane has count >= reqCnt. reqCnt = 0 matches on the first COUNT cycle.
- detectQuiet additionally matches when rxElectricalIdle = 1.
- lanesPassed = per-lane (count >= reqCnt) & laneMask, captured on the exit cycle.
- Match exitTo, first applicable rule:
  - rcvrCfgToIdle -> recoveryIdle.
  - phase1 & eqRedo -> recoveryRcvrLock.
  - recoveryIdle -> L0.
  - recoverySpeed -> recoverywait.
  - recoverySpeedeieos: trainToGen < 3 -> recoveryRcvrLock; otherwise -> phase0.
  - Otherwise substate+1.
- Timeout in substates 0..9: reason 01, exitTo = substate+1.
- Timeout in any other substate: reason 10, exitTo = detectQuiet.
- Match and timeout in the same cycle: match wins.
- laneMask = 0: never matches; resolves only by timeout.
- Abort: substateValid with substate != lastSub while in COUNT.
  - DONE with reason 11, exitTo = latched substate.
  - Then IDLE immediately re-arms with the new request, so no request is lost.
- Repeat requests with substate == lastSub are ignored.
- Latency: request to first COUNT cycle = 2 clks; decision to finish = 1 clk.
- Asserting reset mid-operation returns to IDLE with no finish pulse.

Optional Feature:
- Macro RX_PARTIAL_WIDTH_EN.
- Defined: on timeout in a substate with reqCnt > 0, if popcount(lanesPassed) >= popcount(laneMask)/2 and > 0:
  - reason 00, exitTo computed by the match rules.
  - lanesPassed reports the degraded width.
- Not defined: timeout always follows the timeout rules; the logic is absent.

Test Plan:
- TICKS_PER_MS=10, 4 lanes masked, substate=2, counts 8,8,8,8 on cycle 5 -> finish cycle 6, exitTo=3, reason 00, lanesPassed=4'hF.
- substate=11, lane 2 count stuck at 3, others 8 -> after 480 COUNT cycles finish, exitTo=0, reason 10, lanesPassed=4'hB.
- substate=18, gen=3, GEN3_PIPEWIDTH=16, counts 4 -> exitTo=10, reason 00.
- substate=13 counting, then substate=19 request -> finish reason 11 exitTo=13, then re-arm; counts 1 -> exitTo=14 when trainToGen=3, exitTo=11 when trainToGen=2.
- Same-cycle match and timeout on substate=4 -> reason 00; laneMask=0 on substate=5 -> timeout at 240 cycles, reason 01, exitTo=6.
- RX_PARTIAL_WIDTH_EN defined, substate=11, 2 of 4 lanes pass -> timeout gives reason 00, exitTo=12, lanesPassed=4'h3; undefined -> reason 10, exitTo=0.

Source files
------------

// File: rtl/rx_substate_evaluator.sv
// rx_substate_evaluator: per-substate RX ordered-set evaluator for the LTSSM.
// Takes a substate request, arms the per-lane checkers, times the substate
// and judges the per-lane match counts against that substate's requirement.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   substate            requested substate (0..20)
//   substateValid       request strobe, sampled every cycle
//   laneMask            participating lanes
//   laneCount           per-lane match counts, lane i at [i*CNTW +: CNTW]
//   rxElectricalIdle    receiver electrical idle (detectQuiet exit)
//   gen, trainToGen     current and target generation
//   rcvrCfgToIdle       forces a match exit to recoveryIdle
//   eqRedo              phase1 redo request
//   finish              one-cycle completion pulse
//   exitTo, exitReason  next substate and reason (00 match, 01 timeout
//                       advance, 10 timeout fail, 11 aborted)
//   lanesPassed         lanes meeting the requirement, valid with finish
//   resetOsCheckers     per-lane checker enable (high while counting)
//   busy                high while arming or counting
//
// Optional: define RX_PARTIAL_WIDTH_EN to let a timeout with at least
// half of the masked lanes passing exit as a degraded-width match.

module rx_substate_evaluator #(
    parameter int MAXLANES       = 16,
    parameter int CNTW           = 5,
    parameter int TICKS_PER_MS   = 1000,
    parameter int TMR_W          = 32,
    parameter int DEVICETYPE     = 0,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               substate,
    input  logic                     substateValid,
    input  logic [MAXLANES-1:0]      laneMask,
    input  logic [MAXLANES*CNTW-1:0] laneCount,
    input  logic                     rxElectricalIdle,
    input  logic [2:0]               gen,
    input  logic [2:0]               trainToGen,
    input  logic                     rcvrCfgToIdle,
    input  logic                     eqRedo,
    output logic                     finish,
    output logic [4:0]               exitTo,
    output logic [1:0]               exitReason,
    output logic [MAXLANES-1:0]      lanesPassed,
    output logic [MAXLANES-1:0]      resetOsCheckers,
    output logic                     busy
);

    localparam logic [4:0] S_DQ   = 5'd0;
    localparam logic [4:0] S_DA   = 5'd1;
    localparam logic [4:0] S_PA   = 5'd2;
    localparam logic [4:0] S_PC   = 5'd3;
    localparam logic [4:0] S_CLWS = 5'd4;
    localparam logic [4:0] S_CLWA = 5'd5;
    localparam logic [4:0] S_CLNA = 5'd6;
    localparam logic [4:0] S_CLNW = 5'd7;
    localparam logic [4:0] S_CC   = 5'd8;
    localparam logic [4:0] S_CI   = 5'd9;
    localparam logic [4:0] S_L0   = 5'd10;
    localparam logic [4:0] S_RRL  = 5'd11;
    localparam logic [4:0] S_RRC  = 5'd12;
    localparam logic [4:0] S_RS   = 5'd13;
    localparam logic [4:0] S_P0   = 5'd14;
    localparam logic [4:0] S_P1   = 5'd15;
    localparam logic [4:0] S_P2   = 5'd16;
    localparam logic [4:0] S_P3   = 5'd17;
    localparam logic [4:0] S_RI   = 5'd18;
    localparam logic [4:0] S_RSE  = 5'd19;
    localparam logic [4:0] S_RW   = 5'd20;

    // Idle-symbol requirement: 64 symbols expressed in PIPE words.
    localparam logic [6:0] IDLE_G1 = 7'(64 / GEN1_PIPEWIDTH);
    localparam logic [6:0] IDLE_G2 = 7'(64 / GEN2_PIPEWIDTH);
    localparam logic [6:0] IDLE_G3 = 7'(64 / GEN3_PIPEWIDTH);
    localparam logic [6:0] IDLE_G4 = 7'(64 / GEN4_PIPEWIDTH);
    localparam logic [6:0] IDLE_G5 = 7'(64 / GEN5_PIPEWIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [4:0]          r_lastSub;
    logic [6:0]          r_reqCnt;
    logic [5:0]          r_tms;
    logic [TMR_W-1:0]    r_timer;
    logic                r_pendValid;
    logic [4:0]          r_pendSub;
    logic [4:0]          r_exitTo;
    logic [1:0]          r_exitReason;
    logic [MAXLANES-1:0] r_lanesPassed;

    logic [4:0]          w_reqSub;
    logic                w_reqStrobe;
    logic                w_lkValid;
    logic [6:0]          w_lkCnt;
    logic [5:0]          w_lkTms;
    logic [6:0]          w_idleCnt;
    logic                w_start;
    logic [MAXLANES-1:0] w_laneOk;
    logic [MAXLANES-1:0] w_lanesPass;
    logic                w_match;
    logic                w_timeout;
    logic                w_abort;
    logic [4:0]          w_matchExit;
    logic [4:0]          w_toExit;
    logic [1:0]          w_toReason;
    logic                w_exit;
    logic [4:0]          w_exitTo;
    logic [1:0]          w_exitReason;

    // A request displaced by an abort is replayed from IDLE.
    assign w_reqSub    = r_pendValid ? r_pendSub : substate;
    assign w_reqStrobe = r_pendValid | substateValid;

    always_comb begin
        w_idleCnt = IDLE_G1;
        case (gen)
            3'd2:    w_idleCnt = IDLE_G2;
            3'd3:    w_idleCnt = IDLE_G3;
            3'd4:    w_idleCnt = IDLE_G4;
            3'd5:    w_idleCnt = IDLE_G5;
            default: w_idleCnt = IDLE_G1;
        endcase
    end

    always_comb begin
        w_lkValid = 1'b1;
        w_lkCnt   = 7'd0;
        w_lkTms   = 6'd0;
        case (w_reqSub)
            S_DQ, S_DA: begin
                w_lkCnt = 7'd0;
                w_lkTms = 6'd0;
            end
            S_PA, S_CC: begin
                w_lkCnt = 7'd8;
                w_lkTms = 6'd24;
            end
            S_CLWS, S_CLWA, S_CLNA, S_P0, S_P2, S_P3: begin
                w_lkCnt = 7'd2;
                w_lkTms = 6'd24;
            end
            // Downstream port only listens in phase1.
            S_P1: begin
                w_lkCnt = (DEVICETYPE == 0) ? 7'd0 : 7'd2;
                w_lkTms = 6'd24;
            end
            S_CLNW: begin
                w_lkCnt = 7'd2;
                w_lkTms = 6'd2;
            end
            S_PC, S_RRL, S_RRC: begin
                w_lkCnt = 7'd8;
                w_lkTms = 6'd48;
            end
            S_CI, S_RI: begin
                w_lkCnt = w_idleCnt;
                w_lkTms = 6'd2;
            end
            S_RS, S_RSE: begin
                w_lkCnt = 7'd1;
                w_lkTms = 6'd48;
            end
            S_L0: begin
                w_lkValid = (DEVICETYPE == 1);
                w_lkCnt   = 7'd1;
                w_lkTms   = 6'd48;
            end
            default: w_lkValid = 1'b0;
        endcase
    end

    assign w_start = (r_state == ST_IDLE) && w_reqStrobe &&
                     w_lkValid && (w_reqSub != r_lastSub);

    always_comb begin
        w_laneOk = '0;
        for (int i = 0; i < MAXLANES; i++) begin
            w_laneOk[i] = 32'(laneCount[i*CNTW +: CNTW]) >=
                          32'(r_reqCnt);
        end
    end

    assign w_lanesPass = w_laneOk & laneMask;

    assign w_match = ((laneMask != '0) && (w_lanesPass == laneMask)) ||
                     ((r_lastSub == S_DQ) && rxElectricalIdle);

    // Timer is loaded with the full budget; the last budget cycle is
    // the one that sees 1, so COUNT lasts at most tms*TICKS_PER_MS.
    assign w_timeout = (r_timer <= TMR_W'(1));

    assign w_abort = substateValid && (substate != r_lastSub);

    always_comb begin
        w_matchExit = r_lastSub + 5'd1;
        if (rcvrCfgToIdle) begin
            w_matchExit = S_RI;
        end else if ((r_lastSub == S_P1) && eqRedo) begin
            w_matchExit = S_RRL;
        end else if (r_lastSub == S_RI) begin
            w_matchExit = S_L0;
        end else if (r_lastSub == S_RS) begin
            w_matchExit = S_RW;
        end else if (r_lastSub == S_RSE) begin
            w_matchExit = (trainToGen < 3'd3) ? S_RRL : S_P0;
        end
    end

    always_comb begin
        if (r_lastSub <= S_CI) begin
            w_toReason = 2'b01;
            w_toExit   = r_lastSub + 5'd1;
        end else begin
            w_toReason = 2'b10;
            w_toExit   = S_DQ;
        end
    end

`ifdef RX_PARTIAL_WIDTH_EN
    function automatic logic [6:0] popcnt(
        input logic [MAXLANES-1:0] v
    );
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < MAXLANES; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    logic [6:0] w_passCnt;
    logic [6:0] w_maskCnt;
    logic       w_partial;

    assign w_passCnt = popcnt(w_lanesPass);
    assign w_maskCnt = popcnt(laneMask);
    assign w_partial = (r_reqCnt != 7'd0) && (w_passCnt != 7'd0) &&
                       (w_passCnt >= (w_maskCnt >> 1));
`endif

    // Abort outranks everything: the LTSSM has already moved on.
    always_comb begin
        w_exit       = 1'b0;
        w_exitTo     = 5'd0;
        w_exitReason = 2'b00;
        if (w_abort) begin
            w_exit       = 1'b1;
            w_exitReason = 2'b11;
            w_exitTo     = r_lastSub;
        end else if (w_match) begin
            w_exit       = 1'b1;
            w_exitReason = 2'b00;
            w_exitTo     = w_matchExit;
        end else if (w_timeout) begin
            w_exit = 1'b1;
`ifdef RX_PARTIAL_WIDTH_EN
            if (w_partial) begin
                w_exitReason = 2'b00;
                w_exitTo     = w_matchExit;
            end else begin
                w_exitReason = w_toReason;
                w_exitTo     = w_toExit;
            end
`else
            w_exitReason = w_toReason;
            w_exitTo     = w_toExit;
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_ARM;
            ST_ARM:   w_next = ST_COUNT;
            ST_COUNT: if (w_exit) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastSub     <= 5'h1F;
            r_reqCnt      <= 7'd0;
            r_tms         <= 6'd0;
            r_timer       <= '0;
            r_pendValid   <= 1'b0;
            r_pendSub     <= 5'd0;
            r_exitTo      <= 5'd0;
            r_exitReason  <= 2'b00;
            r_lanesPassed <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pendValid <= 1'b0;
                    if (w_start) begin
                        r_lastSub <= w_reqSub;
                        r_reqCnt  <= w_lkCnt;
                        r_tms     <= w_lkTms;
                    end
                end
                ST_ARM: begin
                    r_timer <= TMR_W'(r_tms) * TMR_W'(TICKS_PER_MS);
                end
                ST_COUNT: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                    if (w_exit) begin
                        r_exitTo      <= w_exitTo;
                        r_exitReason  <= w_exitReason;
                        r_lanesPassed <= w_lanesPass;
                    end
                    if (w_abort) begin
                        r_pendValid <= 1'b1;
                        r_pendSub   <= substate;
                    end
                end
                default: ;
            endcase
        end
    end

    assign finish          = (r_state == ST_DONE);
    assign busy            = (r_state == ST_ARM) || (r_state == ST_COUNT);
    assign resetOsCheckers = (r_state == ST_COUNT) ? laneMask : '0;
    assign exitTo          = r_exitTo;
    assign exitReason      = r_exitReason;
    assign lanesPassed     = r_lanesPassed;

endmodule

// File: tb/tb_rx_substate_evaluator.sv
// tb_rx_substate_evaluator: directed bench for rx_substate_evaluator,
// 4 lanes, 10 ticks per ms, GEN3 PIPE width 16.

module tb_rx_substate_evaluator;

    logic        clk;
    logic        reset;
    logic [4:0]  substate;
    logic        substateValid;
    logic [3:0]  laneMask;
    logic [19:0] laneCount;
    logic        rxElectricalIdle;
    logic [2:0]  gen;
    logic [2:0]  trainToGen;
    logic        rcvrCfgToIdle;
    logic        eqRedo;
    logic        finish;
    logic [4:0]  exitTo;
    logic [1:0]  exitReason;
    logic [3:0]  lanesPassed;
    logic [3:0]  resetOsCheckers;
    logic        busy;

    int n_chk;
    int n_err;
    int n;
    int early;

    rx_substate_evaluator #(
        .MAXLANES(4),
        .CNTW(5),
        .TICKS_PER_MS(10),
        .TMR_W(32),
        .DEVICETYPE(0),
        .GEN3_PIPEWIDTH(16)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .substate(substate),
        .substateValid(substateValid),
        .laneMask(laneMask),
        .laneCount(laneCount),
        .rxElectricalIdle(rxElectricalIdle),
        .gen(gen),
        .trainToGen(trainToGen),
        .rcvrCfgToIdle(rcvrCfgToIdle),
        .eqRedo(eqRedo),
        .finish(finish),
        .exitTo(exitTo),
        .exitReason(exitReason),
        .lanesPassed(lanesPassed),
        .resetOsCheckers(resetOsCheckers),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cnts(input logic [4:0] c3, input logic [4:0] c2,
                        input logic [4:0] c1, input logic [4:0] c0);
        laneCount = {c3, c2, c1, c0};
    endtask

    // Drive a one-cycle request; returns in the cycle after the edge.
    task automatic req(input logic [4:0] s);
        substate      = s;
        substateValid = 1'b1;
        step();
        substateValid = 1'b0;
    endtask

    task automatic wait_fin(input int budget, output int cyc);
        cyc = 0;
        while (finish !== 1'b1 && cyc < budget) begin
            step();
            cyc++;
        end
        if (finish !== 1'b1) chk("fin_tmo", {31'd0, finish}, 32'd1);
    endtask

    task automatic expect_exit(input string t, input logic [4:0] to,
                               input logic [1:0] rsn,
                               input logic [3:0] lp);
        chk({t, ".finish"}, {31'd0, finish}, 32'd1);
        chk({t, ".exitTo"}, {27'd0, exitTo}, {27'd0, to});
        chk({t, ".reason"}, {30'd0, exitReason}, {30'd0, rsn});
        chk({t, ".lanes"}, {28'd0, lanesPassed}, {28'd0, lp});
        step();
        chk({t, ".pulse"}, {31'd0, finish}, 32'd0);
        chk({t, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_chk            = 0;
        n_err            = 0;
        reset            = 1'b0;
        substate         = 5'd0;
        substateValid    = 1'b0;
        laneMask         = 4'hF;
        laneCount        = '0;
        rxElectricalIdle = 1'b0;
        gen              = 3'd1;
        trainToGen       = 3'd1;
        rcvrCfgToIdle    = 1'b0;
        eqRedo           = 1'b0;
        repeat (3) step();
        chk("rst.finish", {31'd0, finish}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.exitTo", {27'd0, exitTo}, 32'd0);
        chk("rst.reason", {30'd0, exitReason}, 32'd0);
        chk("rst.lanes", {28'd0, lanesPassed}, 32'd0);
        chk("rst.roc", {28'd0, resetOsCheckers}, 32'd0);
        reset = 1'b1;
        step();

        // pollingActive: match after a few COUNT cycles.
        req(5'd2);
        chk("pa.armBusy", {31'd0, busy}, 32'd1);
        chk("pa.armRoc", {28'd0, resetOsCheckers}, 32'd0);
        step();
        chk("pa.cntRoc", {28'd0, resetOsCheckers}, 32'hF);
        step();
        step();
        chk("pa.noFin", {31'd0, finish}, 32'd0);
        cnts(5'd8, 5'd8, 5'd8, 5'd8);
        step();
        expect_exit("pa", 5'd3, 2'b00, 4'hF);

        // recoveryRcvrLock: lane 2 stuck, times out after 480 cycles.
        cnts(5'd8, 5'd3, 5'd8, 5'd8);
        req(5'd11);
        step();
        wait_fin(600, n);
        chk("rrl.cycles", n, 32'd480);
`ifdef RX_PARTIAL_WIDTH_EN
        expect_exit("rrl", 5'd12, 2'b00, 4'hB);
`else
        expect_exit("rrl", 5'd0, 2'b10, 4'hB);
`endif

        // recoveryRcvrCfg: two of four lanes pass.
        cnts(5'd0, 5'd0, 5'd8, 5'd8);
        req(5'd12);
        step();
        wait_fin(600, n);
        chk("rrc.cycles", n, 32'd480);
`ifdef RX_PARTIAL_WIDTH_EN
        expect_exit("rrc", 5'd13, 2'b00, 4'h3);
`else
        expect_exit("rrc", 5'd0, 2'b10, 4'h3);
`endif

        // recoveryIdle at gen3: needs 64/16 = 4.
        gen = 3'd3;
        cnts(5'd3, 5'd3, 5'd3, 5'd3);
        req(5'd18);
        gen = 3'd1;
        step();
        step();
        step();
        chk("ri.below", {31'd0, busy}, 32'd1);
        cnts(5'd4, 5'd4, 5'd4, 5'd4);
        step();
        expect_exit("ri", 5'd10, 2'b00, 4'hF);

        // recoverySpeed aborted by a recoverySpeedeieos request.
        cnts(5'd0, 5'd0, 5'd0, 5'd0);
        req(5'd13);
        step();
        step();
        step();
        substate      = 5'd19;
        substateValid = 1'b1;
        step();
        substateValid = 1'b0;
        trainToGen    = 3'd3;
        cnts(5'd1, 5'd1, 5'd1, 5'd1);
        expect_exit("abort", 5'd13, 2'b11, 4'h0);
        step();
        chk("rearm.busy", {31'd0, busy}, 32'd1);
        step();
        wait_fin(10, n);
        chk("rse3.cycles", n, 32'd1);
        expect_exit("rse3", 5'd14, 2'b00, 4'hF);

        // Repeat of the last substate is ignored.
        req(5'd19);
        chk("repeat.busy", {31'd0, busy}, 32'd0);

        // rcvrCfgToIdle overrides the normal successor.
        cnts(5'd2, 5'd2, 5'd2, 5'd2);
        rcvrCfgToIdle = 1'b1;
        req(5'd7);
        step();
        wait_fin(10, n);
        expect_exit("cfgIdle", 5'd18, 2'b00, 4'hF);
        rcvrCfgToIdle = 1'b0;

        // recoverySpeedeieos with trainToGen below 3.
        trainToGen = 3'd2;
        cnts(5'd1, 5'd1, 5'd1, 5'd1);
        req(5'd19);
        step();
        wait_fin(10, n);
        expect_exit("rse2", 5'd11, 2'b00, 4'hF);

        // Match lands on the last timer cycle: match wins.
        cnts(5'd0, 5'd0, 5'd0, 5'd0);
        req(5'd4);
        step();
        early = 0;
        for (int i = 0; i < 239; i++) begin
            step();
            if (finish) early++;
        end
        chk("edge.early", early, 32'd0);
        cnts(5'd2, 5'd2, 5'd2, 5'd2);
        step();
        expect_exit("edge", 5'd5, 2'b00, 4'hF);

        // Empty lane mask never matches: timeout advance.
        laneMask = 4'h0;
        cnts(5'd31, 5'd31, 5'd31, 5'd31);
        req(5'd5);
        step();
        wait_fin(300, n);
        chk("nomask.cycles", n, 32'd240);
        expect_exit("nomask", 5'd6, 2'b01, 4'h0);

        // detectQuiet exits on electrical idle with no lanes.
        rxElectricalIdle = 1'b1;
        req(5'd0);
        step();
        wait_fin(10, n);
        chk("dq.cycles", n, 32'd1);
        expect_exit("dq", 5'd1, 2'b00, 4'h0);
        rxElectricalIdle = 1'b0;
        laneMask = 4'hF;

        // Unlisted substates and L0 on a downstream port are ignored.
        req(5'd21);
        chk("bad.busy", {31'd0, busy}, 32'd0);
        req(5'd10);
        chk("l0.busy", {31'd0, busy}, 32'd0);

        // phase1 downstream: zero requirement, redo to rcvrLock.
        cnts(5'd0, 5'd0, 5'd0, 5'd0);
        eqRedo = 1'b1;
        req(5'd15);
        step();
        wait_fin(10, n);
        chk("p1.cycles", n, 32'd1);
        expect_exit("p1", 5'd11, 2'b00, 4'hF);
        eqRedo = 1'b0;

        // Reset mid-count: no pulse, lastSub back to its reset value.
        req(5'd3);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("mid.busy", {31'd0, busy}, 32'd0);
        chk("mid.finish", {31'd0, finish}, 32'd0);
        chk("mid.roc", {28'd0, resetOsCheckers}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("mid.quiet", {31'd0, finish}, 32'd0);
        req(5'd3);
        chk("mid.rearm", {31'd0, busy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
